// File: rtl/stopwatch_pkg.sv
// Shared types and helpers for the two-digit BCD stopwatch.
// A digit step is returned as a {next digit, carry} pair.
package stopwatch_pkg;

    typedef logic [3:0] bcd_t;

    localparam bcd_t ONES_MAX = 4'd9;
    localparam bcd_t TENS_MAX = 4'd5;

    typedef struct packed {
        bcd_t digit;
        logic carry;
    } bcd_step_t;

    // Anything at or above max rolls to zero, so a digit can never leave BCD range.
    function automatic bcd_step_t bcd_inc(input bcd_t d, input bcd_t max);
        bcd_step_t r;
        if (d >= max) begin
            r.digit = '0;
            r.carry = 1'b1;
        end else begin
            r.digit = d + 4'd1;
            r.carry = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/stopwatch_counter_bcd_digit.sv
// One BCD digit counting 0..MAX with synchronous clear and a carry-out.
// Carry is high in the cycle the digit wraps from MAX back to zero.
module bcd_digit
    import stopwatch_pkg::*;
#(
    parameter bcd_t MAX = ONES_MAX
) (
    input  logic Clock,
    input  logic Reset,
    input  logic Clear,
    input  logic En,
    output bcd_t Q,
    output logic Carry
);

    bcd_t      q_q;
    bcd_t      q_d;
    bcd_step_t nxt;

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        nxt = bcd_inc(q_q, MAX);
        q_d = q_q;
        if (Clear) begin
            q_d = '0;
        end else if (En) begin
            q_d = nxt.digit;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign Q     = q_q;
    assign Carry = En & nxt.carry;

endmodule

// File: rtl/stopwatch_counter.sv
// Two-digit BCD seconds stopwatch (00..59) on a single clock with an internal step enable.
// Optional lap-hold display freeze is built when STOPWATCH_LAP_HOLD_EN is defined.
module stopwatch_counter
    import stopwatch_pkg::*;
#(
    parameter int unsigned TICK_DIV = 50_000_000
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       StartStop,
    input  logic       Clear,
`ifdef STOPWATCH_LAP_HOLD_EN
    input  logic       Lap,
`endif
    output logic [3:0] Ones,
    output logic [3:0] Tens,
    output logic       Running,
    output logic       Tick,
    output logic       Wrap
);

    localparam int unsigned    PW         = $clog2(TICK_DIV);
    localparam logic [PW-1:0]  PRESC_LAST = PW'(TICK_DIV - 1);

    logic          ss_meta_q, ss_sync_q, ss_prev_q;
    logic          ss_press;
    logic          running_q, running_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          step;
    logic          tick_q, tick_d;
    logic          wrap_q, wrap_d;
    bcd_t          ones_live, tens_live;
    logic          ones_carry, tens_carry;

    assign ss_press = ss_sync_q & ~ss_prev_q;
    assign step     = running_q && (presc_q == PRESC_LAST);

    always_comb begin
        running_d = running_q ^ ss_press;
        presc_d   = presc_q;
        if (Clear) begin
            presc_d = '0;
        end else if (running_q) begin
            presc_d = step ? '0 : presc_q + 1'b1;
        end
        // Clear wins over a same-cycle step, so that step produces no pulses.
        tick_d = step & ~Clear;
        wrap_d = step & ~Clear & tens_carry;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            ss_meta_q <= 1'b0;
            ss_sync_q <= 1'b0;
            ss_prev_q <= 1'b0;
            running_q <= 1'b0;
            presc_q   <= '0;
            tick_q    <= 1'b0;
            wrap_q    <= 1'b0;
        end else begin
            ss_meta_q <= StartStop;
            ss_sync_q <= ss_meta_q;
            ss_prev_q <= ss_sync_q;
            running_q <= running_d;
            presc_q   <= presc_d;
            tick_q    <= tick_d;
            wrap_q    <= wrap_d;
        end
    end

    bcd_digit #(.MAX(ONES_MAX)) u_ones (
        .Clock (Clock),
        .Reset (Reset),
        .Clear (Clear),
        .En    (step),
        .Q     (ones_live),
        .Carry (ones_carry)
    );

    bcd_digit #(.MAX(TENS_MAX)) u_tens (
        .Clock (Clock),
        .Reset (Reset),
        .Clear (Clear),
        .En    (ones_carry),
        .Q     (tens_live),
        .Carry (tens_carry)
    );

`ifdef STOPWATCH_LAP_HOLD_EN
    logic lap_meta_q, lap_sync_q, lap_prev_q;
    logic lap_press;
    logic hold_q, hold_d;
    bcd_t lap_ones_q, lap_ones_d;
    bcd_t lap_tens_q, lap_tens_d;

    assign lap_press = lap_sync_q & ~lap_prev_q;

    always_comb begin
        hold_d     = Clear ? 1'b0 : (hold_q ^ lap_press);
        lap_ones_d = lap_ones_q;
        lap_tens_d = lap_tens_q;
        if (lap_press && !hold_q) begin
            lap_ones_d = ones_live;
            lap_tens_d = tens_live;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            lap_meta_q <= 1'b0;
            lap_sync_q <= 1'b0;
            lap_prev_q <= 1'b0;
            hold_q     <= 1'b0;
            lap_ones_q <= '0;
            lap_tens_q <= '0;
        end else begin
            lap_meta_q <= Lap;
            lap_sync_q <= lap_meta_q;
            lap_prev_q <= lap_sync_q;
            hold_q     <= hold_d;
            lap_ones_q <= lap_ones_d;
            lap_tens_q <= lap_tens_d;
        end
    end

    assign Ones = hold_q ? lap_ones_q : ones_live;
    assign Tens = hold_q ? lap_tens_q : tens_live;
`else
    assign Ones = ones_live;
    assign Tens = tens_live;
`endif

    assign Running = running_q;
    assign Tick    = tick_q;
    assign Wrap    = wrap_q;

endmodule
